register_file_mp: RTL

//  Parametrised multi-read-port register file for the multicycle MIPS datapath.

---
 rtl/regfile_pkg.sv | 24 ++
 rtl/rf_read_port.sv | 46 ++++
 rtl/register_file_mp.sv | 110 +++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-read-port MIPS register file.
package regfile_pkg;

  localparam int unsigned RF_INIT_W   = 64;
  localparam int unsigned RF_DROP_W   = 16;
  localparam logic [RF_DROP_W-1:0] RF_DROP_MAX = 16'hFFFF;

  typedef enum logic {
    RF_INIT  = 1'b0,
    RF_READY = 1'b1
  } rf_state_t;

  // Reset contents of entry idx; caller truncates to its data width. Entry 0 is always zero.
  function automatic logic [RF_INIT_W-1:0] init_value(input int unsigned idx,
                                                       input int unsigned pattern);
    logic [RF_INIT_W-1:0] v;
    v = '0;
    if (pattern == 1 && idx != 0 && (4 * idx) < RF_INIT_W) begin
      v = RF_INIT_W'(1) << (4 * idx);
    end
    return v;
  endfunction

endpackage

// File: rtl/rf_read_port.sv
// One registered read port: address mux, R0 zeroing, write bypass, clear while initialising.
module rf_read_port
  import regfile_pkg::*;
#(
  parameter int unsigned W           = 24,
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned WRITE_FIRST = 1,
  localparam int unsigned AW         = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ready_i,
  input  logic [AW-1:0] rd_addr_i,
  input  logic [W-1:0]  mem_i [DEPTH],
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [W-1:0]  wr_data_i,
  output logic [W-1:0]  rd_data_o
);

  logic [W-1:0] rd_data_d;
  logic [W-1:0] rd_data_q;

  // wr_en_i already excludes R0, so a bypass hit never targets R0.
  always_comb begin
    rd_data_d = '0;
    if (ready_i && rd_addr_i != '0) begin
      if (WRITE_FIRST != 0 && wr_en_i && wr_addr_i == rd_addr_i) begin
        rd_data_d = wr_data_i;
      end else begin
        rd_data_d = mem_i[rd_addr_i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/register_file_mp.sv
// Multi-read-port register file with hardwired-zero R0, sequential reset-content loader
// and a saturating counter of writes aimed at R0.
module register_file_mp
  import regfile_pkg::*;
#(
  parameter int unsigned W            = 24,
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned NRD          = 2,
  parameter int unsigned WRITE_FIRST  = 1,
  parameter int unsigned INIT_PATTERN = 1,
  localparam int unsigned AW          = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NRD*AW-1:0]    Rr,
  input  logic [AW-1:0]        Rw,
  input  logic                 enWrite,
  input  logic [W-1:0]         BusW,
  output logic [NRD*W-1:0]     BusR,
  output logic                 busy,
  output logic [RF_DROP_W-1:0] r0_drops
);

  rf_state_t             state_q, state_d;
  logic [AW-1:0]         idx_q, idx_d;
  logic                  busy_q;
  logic [RF_DROP_W-1:0]  drops_q;
  logic [W-1:0]          mem_q [DEPTH];

  logic                  init_we_c;
  logic                  wr_ok_c;
  logic                  drop_c;
  logic                  ready_c;

  // State register; busy tracks the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RF_INIT;
      idx_q   <= '0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      busy_q  <= (state_d == RF_INIT);
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      RF_INIT: begin
        idx_d = idx_q + AW'(1);
        if (idx_q == AW'(DEPTH - 1)) begin
          state_d = RF_READY;
        end
      end
      RF_READY: state_d = RF_READY;
      default:  state_d = RF_INIT;
    endcase
  end

  always_comb begin
    ready_c   = (state_q == RF_READY);
    init_we_c = (state_q == RF_INIT);
    wr_ok_c   = ready_c && enWrite && (Rw != '0);
    drop_c    = ready_c && enWrite && (Rw == '0);
  end

  // Init loader and user writes share the single write port; storage is not reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (init_we_c) begin
        mem_q[idx_q] <= W'(init_value(int'(idx_q), INIT_PATTERN));
      end else if (wr_ok_c) begin
        mem_q[Rw] <= BusW;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      drops_q <= '0;
    end else if (drop_c && drops_q != RF_DROP_MAX) begin
      drops_q <= drops_q + RF_DROP_W'(1);
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    rf_read_port #(
      .W           (W),
      .DEPTH       (DEPTH),
      .WRITE_FIRST (WRITE_FIRST)
    ) u_rd (
      .clk       (clk),
      .rst       (rst),
      .ready_i   (ready_c),
      .rd_addr_i (Rr[k*AW +: AW]),
      .mem_i     (mem_q),
      .wr_en_i   (wr_ok_c),
      .wr_addr_i (Rw),
      .wr_data_i (BusW),
      .rd_data_o (BusR[k*W +: W])
    );
  end

  assign busy     = busy_q;
  assign r0_drops = drops_q;

endmodule
